// File: rtl/jtag_host_shifter.sv
// rtl/jtag_host_shifter.sv - host-side JTAG driver running IR/DR scans against a TAP target
// Optional JTAG_HOST_TLR_CMD_EN adds cmd_tlr, a command that replays the TAP reset sequence.
module jtag_host_shifter #(
  parameter int MAX_LEN = 32,
  parameter int CLK_DIV = 2
) (
  input  logic               sysclk,
  input  logic               sys_reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_ir,
`ifdef JTAG_HOST_TLR_CMD_EN
  input  logic               cmd_tlr,
`endif
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);

  typedef enum logic [2:0] {INIT, IDLE, SEL, SHIFT, EXIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [5:0]         step_q, step_d;
  logic [DW-1:0]      div_q, div_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               primed_q, primed_d;
  logic               tlr_q, tlr_d;
  logic               ir_q, ir_d;
  logic [5:0]         len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rdata_q, rdata_d;
  logic               rerr_q, rerr_d;
  logic               cyc_end;
  logic               tlr_req;
  logic [5:0]         last_step;

`ifdef JTAG_HOST_TLR_CMD_EN
  assign tlr_req = cmd_tlr;
`else
  assign tlr_req = 1'b0;
`endif

  // TMS to present during tck cycle st of state s (applied at the falling edge).
  function automatic logic tms_for(state_t s, logic [5:0] st, logic ir, logic [5:0] len);
    case (s)
      INIT:    tms_for = (st != 6'd5);
      SEL:     tms_for = (st == 6'd0) || (ir && (st == 6'd1));
      SHIFT:   tms_for = (st == len - 6'd1);
      EXIT:    tms_for = (st == 6'd0);
      default: tms_for = 1'b0;
    endcase
  endfunction

  always_comb begin
    last_step = 6'd0;
    case (state_q)
      INIT:    last_step = 6'd5;
      SEL:     last_step = ir_q ? 6'd3 : 6'd2;
      SHIFT:   last_step = len_q - 6'd1;
      EXIT:    last_step = 6'd1;
      default: last_step = 6'd0;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (sys_reset) begin
      state_q  <= INIT;
      step_q   <= '0;
      div_q    <= '0;
      tck_q    <= 1'b0;
      tms_q    <= 1'b0;
      tdi_q    <= 1'b0;
      primed_q <= 1'b0;
      tlr_q    <= 1'b0;
      ir_q     <= 1'b0;
      len_q    <= '0;
      data_q   <= '0;
      cap_q    <= '0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      div_q    <= div_d;
      tck_q    <= tck_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      primed_q <= primed_d;
      tlr_q    <= tlr_d;
      ir_q     <= ir_d;
      len_q    <= len_d;
      data_q   <= data_d;
      cap_q    <= cap_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    div_d    = div_q;
    tck_d    = tck_q;
    tms_d    = tms_q;
    tdi_d    = tdi_q;
    primed_d = primed_q;
    tlr_d    = tlr_q;
    ir_d     = ir_q;
    len_d    = len_q;
    data_d   = data_q;
    cap_d    = cap_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    cyc_end  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          ir_d   = cmd_ir;
          len_d  = cmd_len;
          data_d = cmd_data;
          cap_d  = '0;
          step_d = '0;
          div_d  = '0;
          tlr_d  = tlr_req;
          if (tlr_req) begin
            state_d  = INIT;
            primed_d = 1'b1;
            tms_d    = 1'b1;
          end else if ((cmd_len == 6'd0) || ({1'b0, cmd_len} > LEN_MAX)) begin
            state_d = DONE;
            rdata_d = '0;
            rerr_d  = 1'b1;
          end else begin
            state_d = SEL;
            tms_d   = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      INIT, SEL, SHIFT, EXIT: begin
        // After reset tms is still 0, so spend one idle-low cycle presenting the first TMS.
        if ((state_q == INIT) && !primed_q) begin
          primed_d = 1'b1;
          tms_d    = 1'b1;
          div_d    = '0;
        end else if (div_q == DIV_LAST) begin
          div_d   = '0;
          tck_d   = !tck_q;
          cyc_end = tck_q;
          if (!tck_q && (state_q == SHIFT))
            cap_d[step_q[IW-1:0]] = tdo;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: begin
        state_d  = INIT;
        primed_d = 1'b0;
      end
    endcase

    if (cyc_end) begin
      if (step_q != last_step) begin
        step_d = step_q + 6'd1;
      end else begin
        step_d = '0;
        case (state_q)
          INIT:    state_d = tlr_q ? DONE : IDLE;
          SEL:     state_d = SHIFT;
          SHIFT:   state_d = EXIT;
          default: state_d = DONE;
        endcase
        if (state_d == DONE) begin
          rdata_d = cap_q;
          rerr_d  = 1'b0;
        end
      end
      tms_d = tms_for(state_d, step_d, ir_q, len_q);
      tdi_d = (state_d == SHIFT) ? data_q[step_d[IW-1:0]] : 1'b0;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_err   = rerr_q;
  assign rsp_data  = rdata_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: doc/jtag_host_shifter.md
Name: jtag_host_shifter

Overview:
- Host-side JTAG driver: generates tck/tms/tdi from sysclk and samples tdo, so on-chip logic or a test harness can run IR and DR scans against a JTAG TAP target.
- Accepts one scan command per valid/ready handshake, walks the TAP through the required states, shifts up to MAX_LEN bits LSB-first, and returns the captured TDO bits.
- Tracks TAP state internally; the TAP rests in Run-Test/Idle between commands.

Parameters:
- MAX_LEN, 32: maximum scan length in bits; cmd_data and rsp_data width.
- CLK_DIV, 2: sysclk cycles per tck half-period (legal values ≥1); one tck period = 2*CLK_DIV sysclk cycles.

Ports:
- sysclk  in  1  system clock; all logic on rising edge
- sys_reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE; transfer when cmd_valid && cmd_ready
- cmd_ir  in  1  1 = IR scan, 0 = DR scan
- cmd_len  in  6  bit count; legal range 1..MAX_LEN
- cmd_data  in  MAX_LEN  TDI bits; bit 0 shifted first
- rsp_valid  out  1  one-sysclk pulse at end of command
- rsp_err  out  1  qualified by rsp_valid; 1 = illegal cmd_len
- rsp_data  out  MAX_LEN  captured TDO; bit i = i-th sample; bits ≥ cmd_len are 0; held until next rsp_valid
- busy  out  1  high in every state except IDLE
- tck  out  1  JTAG clock; low when idle
- tms  out  1  JTAG mode select
- tdi  out  1  JTAG data to target
- tdo  in  1  JTAG data from target

Behaviour:
- Reset values: tck=0, tms=0, tdi=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, busy=1. Reset is taken in any state, including mid-scan: the scan is abandoned, no rsp_valid is produced, and the block enters INIT.
- tck timing: every tck cycle is a low phase of CLK_DIV sysclk cycles followed by a high phase of CLK_DIV sysclk cycles.
  - tms and tdi update only at the start of the low phase (falling edge).
  - tdo is sampled in the sysclk cycle where tck goes 0->1 (rising edge).
- States: INIT, IDLE, SEL, SHIFT, EXIT, DONE.
- INIT: 6 tck cycles with tms = 1,1,1,1,1,0 (Test-Logic-Reset, then Run-Test/Idle), then IDLE.
- IDLE: tck=0, tms=0, tdi=0, cmd_ready=1. On handshake, latch cmd_ir, cmd_len and cmd_data.
  - cmd_len of 0 or greater than MAX_LEN: go to DONE with rsp_err=1; no tck activity.
- SEL: DR scan uses tms 1,0,0; IR scan uses tms 1,1,0,0. Ends in Shift-xR.
- SHIFT: cmd_len tck cycles.
  - Cycle i: tdi = data[i]; tms = 0 for i < len-1 and tms = 1 for i = len-1.
  - tdo sampled at rising edge i goes to rsp_data[i].
- EXIT: 2 tck cycles with tms = 1,0 (Update-xR, then Run-Test/Idle). tdi = 0.
- DONE: one sysclk cycle with rsp_valid=1; returns to IDLE on the next cycle.
- Total tck cycles per command: DR = len+5; IR = len+6.
- rsp_valid is asserted in the sysclk cycle after the high phase of the last EXIT tck cycle ends.
- Commands are not queued. cmd_valid outside IDLE is ignored and the command is not consumed.

Optional Feature:
- Macro: JTAG_HOST_TLR_CMD_EN
- Defined: adds input cmd_tlr (1 bit), sampled at the handshake.
  - cmd_tlr=1 overrides cmd_ir and cmd_len and replays the INIT sequence: 6 tck cycles, tms 1,1,1,1,1,0.
  - Then DONE with rsp_data=0 and rsp_err=0.
- Undefined: cmd_tlr port does not exist; the TAP is reset only via sys_reset.

Test Plan (CLK_DIV=2):
- Release sys_reset -> exactly 6 tck pulses with tms 1,1,1,1,1,0, each tck period 4 sysclk; then cmd_ready=1, busy=0.
- DR scan, len=8, data=0xA5, bench TAP in BYPASS (1-bit register, captures 0) -> 13 tck cycles; tdi during shift = 1,0,1,0,0,1,0,1; rsp_data=0x4A; rsp_err=0.
- IR scan, len=4, data=0xE, tdo tied 1 -> tms sequence 1,1,0,0,0,0,0,1,1,0 (10 tck cycles); rsp_data=0xF.
- cmd_len=0, then cmd_len=33 -> no tck edges; rsp_valid with rsp_err=1 one cycle after each handshake; cmd_ready high again on the following cycle.
- Assert sys_reset during SHIFT bit 3 of a 16-bit DR scan -> tck=0 in the next cycle; no rsp_valid; INIT sequence replays; a following DR scan completes correctly.
- With JTAG_HOST_TLR_CMD_EN: cmd_tlr=1 while the TAP model is in Shift-DR -> tms 1,1,1,1,1,0; TAP model ends in Run-Test/Idle; rsp_data=0.
